pwm_slew_limiter: RTL

- Sits between the motor-command registers and the PWM generator's 8-bit width input; one instance per motor channel.
- Ramps the output width toward the commanded target at a bounded rate, so commands cannot jump instantly.
- Forces neutral (127) on pause or on command-watchdog timeout.
- Holds neutral after reset until the first fresh command arrives.

---
 rtl/pwm_slew_limiter.sv | 89 ++++++++
 1 files changed

// File: rtl/pwm_slew_limiter.sv
// pwm_slew_limiter: rate-limits the PWM width toward the commanded target, with pause and watchdog failsafe
module pwm_slew_limiter #(
    parameter int STEP_DIV = 255,
    parameter int MAX_STEP = 4,
    parameter int NEUTRAL  = 127,
    parameter int WDOG_MS  = 500
) (
    input  logic       clk_255kHz,
    input  logic       reset,
    input  logic [7:0] target,
    input  logic       target_strobe,
    input  logic       pause,
    output logic [7:0] width,
    output logic       at_target,
    output logic       failsafe
);
    localparam int WDOG_CYC = WDOG_MS * 255;
    localparam int WW       = $clog2(WDOG_CYC);
    localparam int DW       = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {FAILSAFE, RUN, PAUSED} state_t;

    state_t          state_q, state_d;
    logic [7:0]      tgt_q, tgt_d;
    logic [7:0]      width_q, width_d;
    logic [DW-1:0]   div_q, div_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            tick;
    logic [7:0]      goal;
    logic signed [8:0] diff;
    logic [8:0]      mag;

    // Free-running slew divider; tick marks the last count of each period
    always_comb begin
        tick  = div_q == DW'(STEP_DIV - 1);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Mode control: strobes latch a fresh target, watchdog only runs while tracking it
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        wdog_d  = '0;
        case (state_q)
            FAILSAFE: if (target_strobe && !pause) begin
                state_d = RUN;
                tgt_d   = target;
            end
            RUN: if (pause) state_d = PAUSED;
                 else if (target_strobe) tgt_d = target;
                 else if (wdog_q == WW'(WDOG_CYC - 1)) state_d = FAILSAFE;
                 else wdog_d = wdog_q + 1'b1;
            PAUSED: if (!pause) state_d = FAILSAFE;
            default: state_d = FAILSAFE;
        endcase
    end

    // Slew: snap to goal when within one step, else move one full step toward it
    always_comb begin
        goal    = state_q == RUN ? tgt_q : 8'(NEUTRAL);
        diff    = $signed({1'b0, goal}) - $signed({1'b0, width_q});
        mag     = diff[8] ? 9'(-diff) : 9'(diff);
        width_d = !tick ? width_q
                : mag <= 9'(MAX_STEP) ? goal
                : diff[8] ? width_q - 8'(MAX_STEP)
                : width_q + 8'(MAX_STEP);
    end

    // State registers with synchronous reset to neutral failsafe
    always_ff @(posedge clk_255kHz) begin
        if (reset) begin
            state_q <= FAILSAFE;
            tgt_q   <= 8'(NEUTRAL);
            width_q <= 8'(NEUTRAL);
            div_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            width_q <= width_d;
            div_q   <= div_d;
            wdog_q  <= wdog_d;
        end
    end

    assign width     = width_q;
    assign at_target = width_q == goal;
    assign failsafe  = state_q == FAILSAFE;
endmodule
